// File: rtl/lutram_pattern_array.sv
// rtl/lutram_pattern_array.sv - seed-patterned LUTRAM fill and readback checker
// Optional build macro: LUTRAM_INJECT_EN (adds inj_mask to corrupt the addr-0 write).
module lutram_pattern_array #(
  parameter int         G_SIZE  = 4,
  parameter int         G_DEPTH = 64,
  parameter logic [7:0] G_SEED  = 8'hA5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              check_only,
  input  logic              seed_ovr,
  input  logic [7:0]        seed_in,
`ifdef LUTRAM_INJECT_EN
  input  logic [G_SIZE-1:0] inj_mask,
`endif
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [15:0]       err_count,
  output logic [G_SIZE-1:0] rd_data
);

  localparam int AW = $clog2(G_DEPTH);
  localparam logic [AW-1:0] LAST_ADDR = AW'(G_DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [7:0]        seed_q;
  logic              start_acc;
  logic              we_fsm;
  logic              ram_we;
  logic [G_SIZE-1:0] ram_d;
  logic [G_SIZE-1:0] ram_o;
  logic [G_SIZE-1:0] exp_q;
  logic              vld_q;
  logic              busy_q, done_q, err_q;
  logic [15:0]       err_count_q;
  logic [G_SIZE-1:0] rd_data_q;
`ifdef LUTRAM_INJECT_EN
  logic [G_SIZE-1:0] inj_q;
`endif

  generate
    if (!(G_DEPTH == 32 || G_DEPTH == 64 || G_DEPTH == 128)) begin : g_bad_depth
      $error("lutram_pattern_array: G_DEPTH must be 32, 64 or 128");
    end
    if (G_SIZE < 1 || G_SIZE > 64) begin : g_bad_size
      $error("lutram_pattern_array: G_SIZE must be 1..64");
    end
  endgenerate

  // Channel i at address a carries seed bit (a+i) mod 8.
  function automatic logic [G_SIZE-1:0] pat_word(input logic [7:0] s, input logic [AW-1:0] a);
    logic [G_SIZE-1:0] w;
    logic [2:0]        idx;
    w = '0;
    for (int i = 0; i < G_SIZE; i++) begin
      idx  = a[2:0] + 3'(i);
      w[i] = s[idx];
    end
    return w;
  endfunction

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    start_acc = 1'b0;
    we_fsm    = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          start_acc = 1'b1;
          addr_d    = '0;
          state_d   = check_only ? S_READ : S_WRITE;
        end
      end
      S_WRITE: begin
        we_fsm = 1'b1;
        if (addr_q == LAST_ADDR) begin
          addr_d  = '0;
          state_d = S_READ;
        end else begin
          addr_d = addr_q + AW'(1);
        end
      end
      S_READ: begin
        if (addr_q == LAST_ADDR) begin
          addr_d  = '0;
          state_d = S_FLUSH;
        end else begin
          addr_d = addr_q + AW'(1);
        end
      end
      S_FLUSH: state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  // Reset must also suppress the write that would land on the reset edge.
  assign ram_we = we_fsm & rst_n;

`ifdef LUTRAM_INJECT_EN
  assign ram_d = pat_word(seed_q, addr_q) ^ ((addr_q == '0) ? inj_q : '0);
`else
  assign ram_d = pat_word(seed_q, addr_q);
`endif

  genvar gi;
  generate
    for (gi = 0; gi < G_SIZE; gi++) begin : g_ch
      if (G_DEPTH == 32) begin : g_ram32x1s
        (* dont_touch = "true", ram_style = "distributed" *) logic mem [32];
        always_ff @(posedge clk) begin
          if (ram_we) mem[addr_q] <= ram_d[gi];
        end
        assign ram_o[gi] = mem[addr_q];
      end else if (G_DEPTH == 128) begin : g_ram128x1s
        (* dont_touch = "true", ram_style = "distributed" *) logic mem [128];
        always_ff @(posedge clk) begin
          if (ram_we) mem[addr_q] <= ram_d[gi];
        end
        assign ram_o[gi] = mem[addr_q];
      end else begin : g_ram64x1s
        (* dont_touch = "true", ram_style = "distributed" *) logic mem [64];
        always_ff @(posedge clk) begin
          if (ram_we) mem[addr_q] <= ram_d[gi];
        end
        assign ram_o[gi] = mem[addr_q];
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      seed_q      <= '0;
      exp_q       <= '0;
      vld_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      err_count_q <= '0;
      rd_data_q   <= '0;
`ifdef LUTRAM_INJECT_EN
      inj_q       <= '0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      if (start_acc) begin
        seed_q <= seed_ovr ? seed_in : G_SEED;
`ifdef LUTRAM_INJECT_EN
        inj_q  <= inj_mask;
`endif
      end
      vld_q <= (state_q == S_READ);
      if (state_q == S_READ) begin
        rd_data_q <= ram_o;
        exp_q     <= pat_word(seed_q, addr_q);
      end
      // Compare stage trails the read stage by one cycle; FLUSH drains it.
      if (start_acc) begin
        err_count_q <= '0;
      end else if (vld_q && (rd_data_q != exp_q) && (err_count_q != 16'hFFFF)) begin
        err_count_q <= err_count_q + 16'd1;
      end
      busy_q <= (state_q == S_WRITE) || (state_q == S_READ) || (state_q == S_FLUSH);
      done_q <= (state_q == S_DONE) && !start_acc;
      err_q  <= (state_q == S_DONE) && !start_acc && (err_count_q != '0);
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign err_count = err_count_q;
  assign rd_data   = rd_data_q;

endmodule

// File: tb/tb_lutram_pattern_array.sv
// tb/tb_lutram_pattern_array.sv - directed checks of fill, readback, reset and depth variants
module tb_lutram_pattern_array;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        rst_n;
  logic        start, check_only, seed_ovr;
  logic [7:0]  seed_in;
  logic        busy, done, err;
  logic [15:0] err_count;
  logic [3:0]  rd_data;

  logic        start_b, check_only_b, seed_ovr_b;
  logic [7:0]  seed_in_b;
  logic        busy32, done32, err32, busy128, done128, err128;
  logic [15:0] err_count32, err_count128;
  logic [3:0]  rd_data32, rd_data128;
`ifdef LUTRAM_INJECT_EN
  logic [3:0]  inj_mask, inj_mask_b;
`endif

  lutram_pattern_array #(.G_SIZE(4), .G_DEPTH(64), .G_SEED(8'hA5)) u64 (
    .clk(clk), .rst_n(rst_n), .start(start), .check_only(check_only),
    .seed_ovr(seed_ovr), .seed_in(seed_in),
`ifdef LUTRAM_INJECT_EN
    .inj_mask(inj_mask),
`endif
    .busy(busy), .done(done), .err(err), .err_count(err_count), .rd_data(rd_data)
  );

  lutram_pattern_array #(.G_SIZE(4), .G_DEPTH(32), .G_SEED(8'hA5)) u32 (
    .clk(clk), .rst_n(rst_n), .start(start_b), .check_only(check_only_b),
    .seed_ovr(seed_ovr_b), .seed_in(seed_in_b),
`ifdef LUTRAM_INJECT_EN
    .inj_mask(inj_mask_b),
`endif
    .busy(busy32), .done(done32), .err(err32), .err_count(err_count32), .rd_data(rd_data32)
  );

  lutram_pattern_array #(.G_SIZE(4), .G_DEPTH(128), .G_SEED(8'hA5)) u128 (
    .clk(clk), .rst_n(rst_n), .start(start_b), .check_only(check_only_b),
    .seed_ovr(seed_ovr_b), .seed_in(seed_in_b),
`ifdef LUTRAM_INJECT_EN
    .inj_mask(inj_mask_b),
`endif
    .busy(busy128), .done(done128), .err(err128), .err_count(err_count128), .rd_data(rd_data128)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start sampled at edge 0; n is the edge after which done is first seen.
  task automatic run64(input logic co, input logic ovr, input logic [7:0] sd,
                       input int probe_edge, input int pulse_edge,
                       output int n, output int bcnt, output logic [3:0] probe);
    check_only = co;
    seed_ovr   = ovr;
    seed_in    = sd;
    start      = 1'b1;
    tick();
    start      = 1'b0;
    check_only = ~co;
    seed_ovr   = ~ovr;
    seed_in    = ~sd;
    n     = 0;
    bcnt  = 0;
    probe = '0;
    while (n < 400) begin
      start = (n + 1 == pulse_edge);
      tick();
      n++;
      if (busy) bcnt++;
      if (n == probe_edge) probe = rd_data;
      if (done) break;
    end
    start = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int         n, bcnt, n32, n128;
    logic [3:0] probe;

    rst_n = 1'b0;
    start = 1'b0; check_only = 1'b0; seed_ovr = 1'b0; seed_in = 8'h00;
    start_b = 1'b0; check_only_b = 1'b0; seed_ovr_b = 1'b0; seed_in_b = 8'h00;
`ifdef LUTRAM_INJECT_EN
    inj_mask = 4'b0000; inj_mask_b = 4'b0000;
`endif
    tick();
    tick();
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_err", err, 0);
    chk("reset_err_count", err_count, 0);
    chk("reset_rd_data", rd_data, 0);
    rst_n = 1'b1;
    tick();

    run64(1'b0, 1'b0, 8'h00, 66, 0, n, bcnt, probe);
    chk("fill_done_edge", n, 130);
    chk("fill_busy_cycles", bcnt, 129);
    chk("fill_rd_addr1", probe, 4'b0010);
    chk("fill_err_count", err_count, 0);
    chk("fill_err", err, 0);
    chk("fill_rd_last", rd_data, 4'b1011);

    run64(1'b1, 1'b1, 8'h5A, 0, 0, n, bcnt, probe);
    chk("chk5a_done_edge", n, 66);
    chk("chk5a_busy_cycles", bcnt, 65);
    chk("chk5a_err_count", err_count, 64);
    chk("chk5a_err", err, 1);

    run64(1'b0, 1'b1, 8'h5A, 0, 0, n, bcnt, probe);
    chk("fill5a_done_edge", n, 130);
    chk("fill5a_err_count", err_count, 0);
    chk("fill5a_rd_last", rd_data, 4'b0100);

    // Fill with A5 over 5A contents, reset before address 20 is written.
    check_only = 1'b0;
    seed_ovr   = 1'b0;
    start      = 1'b1;
    tick();
    start = 1'b0;
    repeat (20) tick();
    chk("midwrite_busy", busy, 1);
    rst_n = 1'b0;
    tick();
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_done", done, 0);
    chk("rst_mid_err", err, 0);
    chk("rst_mid_err_count", err_count, 0);
    chk("rst_mid_rd_data", rd_data, 0);
    rst_n = 1'b1;
    tick();
    run64(1'b1, 1'b0, 8'h00, 0, 0, n, bcnt, probe);
    chk("partial_done_edge", n, 66);
    chk("partial_err_count", err_count, 44);
    chk("partial_err", err, 1);

    run64(1'b0, 1'b0, 8'h00, 0, 80, n, bcnt, probe);
    chk("ignstart_done_edge", n, 130);
    chk("ignstart_err_count", err_count, 0);
    repeat (5) tick();
    chk("ignstart_done_held", done, 1);
    chk("ignstart_busy_low", busy, 0);

    check_only_b = 1'b0;
    seed_ovr_b   = 1'b0;
    start_b      = 1'b1;
    tick();
    start_b = 1'b0;
    n = 0; n32 = 0; n128 = 0;
    while (n < 400 && (n32 == 0 || n128 == 0)) begin
      tick();
      n++;
      if (done32 && n32 == 0) n32 = n;
      if (done128 && n128 == 0) n128 = n;
    end
    chk("d32_done_edge", n32, 66);
    chk("d128_done_edge", n128, 258);
    chk("d32_err_count", err_count32, 0);
    chk("d128_err_count", err_count128, 0);
    chk("d32_err", err32, 0);
    chk("d128_err", err128, 0);

`ifdef LUTRAM_INJECT_EN
    inj_mask = 4'b0100;
    run64(1'b0, 1'b0, 8'h00, 0, 0, n, bcnt, probe);
    inj_mask = 4'b0000;
    chk("inj_done_edge", n, 130);
    chk("inj_err_count", err_count, 1);
    chk("inj_err", err, 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lutram_pattern_array.md
Name: lutram_pattern_array

Overview:
- Parametrised LUTRAM array for bitstream-mapping experiments.
- Instantiates G_SIZE single-port distributed-RAM primitives of depth G_DEPTH, each marked DONT_TOUCH.
- A controller FSM fills every LUTRAM with a deterministic, seed-derived pattern, then optionally reads it back and checks it. This places known contents into LUTRAM configuration bits, and the readback confirms the contents were written.

Parameters:
- G_SIZE, 4: number of LUTRAM channels, 1..64.
- G_DEPTH, 64: depth per channel. Legal values are 32, 64 and 128, which select RAM32X1S, RAM64X1S and RAM128X1S respectively. Any other value is an elaboration error.
- G_SEED, 8'hA5: default pattern seed, used when seed_ovr is low.

Ports:
- clk, in, 1: single clock; also drives WCLK of every LUTRAM.
- rst_n, in, 1: synchronous, active-low reset.
- start, in, 1: request a run; sampled in IDLE only.
- check_only, in, 1: sampled with start. 1 skips the fill and runs readback only.
- seed_ovr, in, 1: sampled with start. 1 selects seed_in instead of G_SEED.
- seed_in, in, 8: alternate seed.
- busy, out, 1: high in WRITE, READ and FLUSH.
- done, out, 1: high in DONE.
- err, out, 1: high when err_count is nonzero in DONE.
- err_count, out, 16: number of addresses with at least one mismatching channel; saturates at 16'hFFFF.
- rd_data, out, G_SIZE: registered readback word from the READ phase.

Behaviour:
- Reset (rst_n low at a clk edge):
  - FSM goes to IDLE.
  - busy, done, err and err_count go to 0; rd_data goes to 0; address counter goes to 0; all WE go to 0.
  - LUTRAM contents are not cleared.
- Address width: AW = clog2(G_DEPTH). The counter runs 0..G_DEPTH-1 with no wrap inside a phase.
- Pattern: pat(i,a) = S[(a+i) mod 8], where S is the latched seed. All channels share address lines; D of channel i is pat(i,addr).
- States:
  - IDLE: start=1 latches seed and check_only, clears err_count and done, and clears addr. Next state is READ if check_only=1, else WRITE.
  - WRITE: WE=1 on all channels for G_DEPTH cycles, addr 0..G_DEPTH-1. After addr=G_DEPTH-1, addr clears and the FSM goes to READ.
  - READ: WE=0 for G_DEPTH cycles.
    - Each cycle registers the asynchronous O outputs into rd_data, together with the expected word and a valid flag (1-cycle compare pipeline).
    - The compare stage increments err_count once per address where rd_data differs from the expected word.
    - After the last address, the FSM goes to FLUSH.
  - FLUSH: one cycle that compares the final registered word, then goes to DONE.
  - DONE: done=1 and err=(err_count!=0). The FSM stays here until start=1, which behaves exactly as start in IDLE (new run, counters cleared).
- start while busy is ignored, with no queuing.
- Latency (start sampled at edge 0):
  - Fill+check: done rises after edge 2*G_DEPTH+2.
  - Check-only: done rises after edge G_DEPTH+2.
- Changes to seed_in, seed_ovr or check_only during a run have no effect.
- err_count saturates and does not wrap. This is unreachable for legal depths, but is still required.
- rst_n low mid-WRITE leaves the LUTRAM partially written. A later check_only run reports mismatches accordingly.

Optional Feature:
- Macro: LUTRAM_INJECT_EN.
- Defined:
  - Adds input port inj_mask [G_SIZE-1:0], latched at start.
  - During WRITE at addr 0 only, D = pat XOR inj_mask, so a nonzero mask yields exactly one error per run.
- Undefined: the port is absent and D = pat always.

Test Plan:
- Fill+check, G_SIZE=4, G_DEPTH=64, seed_ovr=0:
  - busy for 129 cycles; done after edge 130.
  - err_count=0, err=0.
  - rd_data at addr 1 = {S[4],S[3],S[2],S[1]} = 4'b0010 for S=8'hA5.
- Check-only with seed_in=8'h5A after a G_SEED fill: every address mismatches, so err_count=64 and err=1; done after edge 66.
- Reset mid-WRITE at addr 20, then check-only with the same seed:
  - All outputs are 0 right after reset.
  - err_count equals the number of mismatching addresses in 20..63 given the prior contents. From power-on zero contents with S=8'hA5, this is 44 (no address has pat all zeros).
- start pulsed during READ is ignored: done timing is unchanged and only one run occurs.
- G_DEPTH=32 and G_DEPTH=128 builds: correct primitive selected; done after edges 66 and 258; err_count=0.
- With LUTRAM_INJECT_EN and inj_mask=4'b0100: err_count=1, err=1.
